// File: rtl/hamming_codec.sv
// hamming_codec: two-stage pipelined Hamming SEC / SEC-DED encoder-decoder with
// valid/ready handshaking on both sides and saturating corrected/uncorrectable counters.
module hamming_codec #(
  parameter int DATA_W = 4,
  parameter int SECDED = 1,
  parameter int CNT_W = 16,
  localparam int R = DATA_W <= 1 ? 2 : DATA_W <= 4 ? 3 : DATA_W <= 11 ? 4 : DATA_W <= 26 ? 5 : DATA_W <= 57 ? 6 : 7,
  localparam int CW = DATA_W + R + SECDED
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic              InMode,
  input  logic [DATA_W-1:0] InData,
  input  logic [CW-1:0]     InCode,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              OutMode,
  output logic [DATA_W-1:0] OutData,
  output logic [CW-1:0]     OutCode,
  output logic [R-1:0]      OutSyndrome,
  output logic              OutCorrected,
  output logic              OutUncorrectable,
  input  logic              CntClear,
  output logic [CNT_W-1:0]  CorrCount,
  output logic [CNT_W-1:0]  UncorrCount
);
  function automatic int data_pos(input int j);
    int p = 2;
    int k = -1;
    while (k < j) begin
      p++;
      if ((p & (p - 1)) != 0) k++;
    end
    return p;
  endfunction

  logic [R-1:0] dpos [DATA_W];
  for (genvar g = 0; g < DATA_W; g++) begin : g_pos
    assign dpos[g] = R'(data_pos(g));
  end

  logic              v1_q, v1_d, mode1_q, mode1_d, o1_q, o1_d;
  logic [CW-1:0]     code1_q, code1_d;
  logic [R-1:0]      s1_q, s1_d;
  logic              v2_q, v2_d, mode2_q, mode2_d, corr2_q, corr2_d, unc2_q, unc2_d;
  logic [CW-1:0]     code2_q, code2_d;
  logic [R-1:0]      syn2_q, syn2_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d, unc_cnt_q, unc_cnt_d;
  logic [R-1:0]      p_enc, p_rx;
  logic [CW-1:0]     code_enc, flip;
  logic              adv1, adv2, hit, dec_corr, dec_unc, fix, hs;

  assign adv2 = !v2_q || OutReady;
  assign adv1 = !v1_q || adv2;
  assign InReady = adv1;

  // Each parity bit is the XOR of the positions of all set data bits, bit-sliced
  always_comb begin
    p_enc = '0;
    p_rx = '0;
    for (int j = 0; j < DATA_W; j++) begin
      p_enc = p_enc ^ (InData[j] ? dpos[j] : '0);
      p_rx = p_rx ^ (InCode[R+j] ? dpos[j] : '0);
    end
    code_enc = CW'({^{InData, p_enc}, InData, p_enc});
    v1_d = adv1 ? InValid : v1_q;
    mode1_d = adv1 ? InMode : mode1_q;
    code1_d = adv1 ? (InMode ? InCode : code_enc) : code1_q;
    s1_d = adv1 ? (InMode ? p_rx ^ InCode[R-1:0] : '0) : s1_q;
    o1_d = adv1 ? InMode && SECDED != 0 && (^InCode) : o1_q;
  end

  always_comb begin
    flip = '0;
    for (int i = 0; i < R; i++) flip[i] = s1_q == R'(1 << i);
    for (int j = 0; j < DATA_W; j++) flip[R+j] = s1_q == dpos[j];
    hit = |flip[DATA_W+R-1:0];
    if (SECDED != 0) flip[CW-1] = o1_q && s1_q == '0;
    dec_corr = SECDED != 0 ? o1_q && (s1_q == '0 || hit) : hit;
    dec_unc = s1_q != '0 && (SECDED != 0 ? !o1_q || !hit : !hit);
    fix = mode1_q && dec_corr;
    v2_d = adv2 ? v1_q : v2_q;
    mode2_d = adv2 ? mode1_q : mode2_q;
    code2_d = adv2 ? code1_q ^ (fix ? flip : '0) : code2_q;
    syn2_d = adv2 ? s1_q : syn2_q;
    corr2_d = adv2 ? fix : corr2_q;
    unc2_d = adv2 ? mode1_q && dec_unc : unc2_q;
    hs = v2_q && OutReady;
    corr_cnt_d = CntClear ? '0 : (hs && corr2_q && corr_cnt_q != '1) ? corr_cnt_q + CNT_W'(1) : corr_cnt_q;
    unc_cnt_d = CntClear ? '0 : (hs && unc2_q && unc_cnt_q != '1) ? unc_cnt_q + CNT_W'(1) : unc_cnt_q;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      v1_q <= 1'b0;
      mode1_q <= 1'b0;
      o1_q <= 1'b0;
      code1_q <= '0;
      s1_q <= '0;
      v2_q <= 1'b0;
      mode2_q <= 1'b0;
      corr2_q <= 1'b0;
      unc2_q <= 1'b0;
      code2_q <= '0;
      syn2_q <= '0;
      corr_cnt_q <= '0;
      unc_cnt_q <= '0;
    end else begin
      v1_q <= v1_d;
      mode1_q <= mode1_d;
      o1_q <= o1_d;
      code1_q <= code1_d;
      s1_q <= s1_d;
      v2_q <= v2_d;
      mode2_q <= mode2_d;
      corr2_q <= corr2_d;
      unc2_q <= unc2_d;
      code2_q <= code2_d;
      syn2_q <= syn2_d;
      corr_cnt_q <= corr_cnt_d;
      unc_cnt_q <= unc_cnt_d;
    end
  end

  assign OutValid = v2_q;
  assign OutMode = mode2_q;
  assign OutCode = code2_q;
  assign OutData = code2_q[R +: DATA_W];
  assign OutSyndrome = syn2_q;
  assign OutCorrected = corr2_q;
  assign OutUncorrectable = unc2_q;
  assign CorrCount = corr_cnt_q;
  assign UncorrCount = unc_cnt_q;
endmodule

// File: tb/tb_hamming_codec.sv
// tb_hamming_codec: directed checks of encode, SEC-DED decode, handshaking, stalls,
// counter saturation/clear and reset across four parameterisations sharing one handshake.
module tb_hamming_codec;
  logic clk = 0, rst_n = 0, rst_c = 0, in_valid = 0, in_mode = 0, out_ready = 1, cnt_clear = 0;
  logic [3:0] a_data = 0;
  logic [7:0] a_code = 0;
  logic [10:0] b_data = 0;
  logic [15:0] b_code = 0;
  logic a_ir, a_ov, a_om, a_cf, a_uf;
  logic [3:0] a_od;
  logic [7:0] a_oc;
  logic [2:0] a_os;
  logic [15:0] a_cc, a_uc;
  logic b_ir, b_ov, b_om, b_cf, b_uf;
  logic [10:0] b_od;
  logic [15:0] b_oc;
  logic [3:0] b_os;
  logic [15:0] b_cc, b_uc;
  logic c_ir, c_ov, c_om, c_cf, c_uf;
  logic [3:0] c_od;
  logic [7:0] c_oc;
  logic [2:0] c_os;
  logic [1:0] c_cc, c_uc;
  logic d_ir, d_ov, d_om, d_cf, d_uf;
  logic [3:0] d_od;
  logic [6:0] d_oc;
  logic [2:0] d_os;
  logic [15:0] d_cc, d_uc;
  int n_vec = 0, n_err = 0, exp_ca = 0, exp_ua = 0;
  int pos11[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  always #5 clk = ~clk;

  hamming_codec #(.DATA_W(4), .SECDED(1), .CNT_W(16)) u_a (
    .Clk(clk), .Rst_n(rst_n), .InValid(in_valid), .InReady(a_ir), .InMode(in_mode), .InData(a_data),
    .InCode(a_code), .OutValid(a_ov), .OutReady(out_ready), .OutMode(a_om), .OutData(a_od), .OutCode(a_oc),
    .OutSyndrome(a_os), .OutCorrected(a_cf), .OutUncorrectable(a_uf), .CntClear(cnt_clear),
    .CorrCount(a_cc), .UncorrCount(a_uc));
  hamming_codec #(.DATA_W(11), .SECDED(1), .CNT_W(16)) u_b (
    .Clk(clk), .Rst_n(rst_n), .InValid(in_valid), .InReady(b_ir), .InMode(in_mode), .InData(b_data),
    .InCode(b_code), .OutValid(b_ov), .OutReady(out_ready), .OutMode(b_om), .OutData(b_od), .OutCode(b_oc),
    .OutSyndrome(b_os), .OutCorrected(b_cf), .OutUncorrectable(b_uf), .CntClear(cnt_clear),
    .CorrCount(b_cc), .UncorrCount(b_uc));
  hamming_codec #(.DATA_W(4), .SECDED(1), .CNT_W(2)) u_c (
    .Clk(clk), .Rst_n(rst_c), .InValid(in_valid), .InReady(c_ir), .InMode(in_mode), .InData(a_data),
    .InCode(a_code), .OutValid(c_ov), .OutReady(out_ready), .OutMode(c_om), .OutData(c_od), .OutCode(c_oc),
    .OutSyndrome(c_os), .OutCorrected(c_cf), .OutUncorrectable(c_uf), .CntClear(cnt_clear),
    .CorrCount(c_cc), .UncorrCount(c_uc));
  hamming_codec #(.DATA_W(4), .SECDED(0), .CNT_W(16)) u_d (
    .Clk(clk), .Rst_n(rst_n), .InValid(in_valid), .InReady(d_ir), .InMode(in_mode), .InData(a_data),
    .InCode(a_code[6:0]), .OutValid(d_ov), .OutReady(out_ready), .OutMode(d_om), .OutData(d_od), .OutCode(d_oc),
    .OutSyndrome(d_os), .OutCorrected(d_cf), .OutUncorrectable(d_uf), .CntClear(cnt_clear),
    .CorrCount(d_cc), .UncorrCount(d_uc));

  function automatic logic [15:0] enc11(input logic [10:0] d);
    logic [3:0] p = '0;
    for (int j = 0; j < 11; j++) if (d[j]) p = p ^ 4'(pos11[j]);
    return {^{d, p}, d, p};
  endfunction

  // Called at a negedge with out_ready=1; returns at the negedge where the result is on Out*
  task automatic xfer(input logic m, input logic [3:0] ad, input logic [7:0] ac, input logic [10:0] bd, input logic [15:0] bc);
    in_valid = 1; in_mode = m; a_data = ad; a_code = ac; b_data = bd; b_code = bc;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", a_ov); end
    n_vec++; if (a_oc !== 8'h00) begin n_err++; $display("FAIL rst_code got %h want 00", a_oc); end
    n_vec++; if (a_cc !== 16'h0 || a_uc !== 16'h0) begin n_err++; $display("FAIL rst_counts got %h/%h want 0/0", a_cc, a_uc); end
    rst_n = 1;
    @(negedge clk);
    n_vec++; if (a_ir !== 1'b1) begin n_err++; $display("FAIL rst_inready got %b want 1", a_ir); end
  endtask

  task automatic test_encode();
    xfer(0, 4'b1011, 8'h00, 11'h001, 16'h0);
    n_vec++; if (a_ov !== 1'b1) begin n_err++; $display("FAIL enc_valid got %b want 1", a_ov); end
    n_vec++; if (a_oc !== 8'h59) begin n_err++; $display("FAIL enc_code got %h want 59", a_oc); end
    n_vec++; if (a_od !== 4'b1011 || a_om !== 1'b0) begin n_err++; $display("FAIL enc_data got %b/%b want 1011/0", a_od, a_om); end
    n_vec++; if (a_os !== 3'b000 || a_cf !== 1'b0 || a_uf !== 1'b0) begin n_err++; $display("FAIL enc_flags got %b%b%b want 00000", a_os, a_cf, a_uf); end
    n_vec++; if (d_oc !== 7'h59) begin n_err++; $display("FAIL enc_sec_code got %h want 59", d_oc); end
    n_vec++; if (b_oc !== 16'h8013) begin n_err++; $display("FAIL enc11_code got %h want 8013", b_oc); end
    xfer(0, 4'b1111, 8'h00, 11'h0, 16'h0);
    n_vec++; if (a_oc !== 8'hFF) begin n_err++; $display("FAIL enc_ff got %h want ff", a_oc); end
    n_vec++; if (d_oc !== 7'h7F) begin n_err++; $display("FAIL enc_sec_ff got %h want 7f", d_oc); end
    xfer(0, 4'b0001, 8'h00, 11'h0, 16'h0);
    n_vec++; if (a_oc !== 8'h8B) begin n_err++; $display("FAIL enc_01 got %h want 8b", a_oc); end
  endtask

  task automatic test_decode_single();
    xfer(1, 4'h0, 8'h79, 11'h0, 16'h0);
    n_vec++; if (a_od !== 4'b1011 || a_oc !== 8'h59) begin n_err++; $display("FAIL dec1_fix got %b/%h want 1011/59", a_od, a_oc); end
    n_vec++; if (a_os !== 3'b110) begin n_err++; $display("FAIL dec1_syn got %b want 110", a_os); end
    n_vec++; if (a_cf !== 1'b1 || a_uf !== 1'b0 || a_om !== 1'b1) begin n_err++; $display("FAIL dec1_flags got c%b u%b m%b want c1 u0 m1", a_cf, a_uf, a_om); end
    n_vec++; if (d_oc !== 7'h59 || d_cf !== 1'b1) begin n_err++; $display("FAIL dec1_sec got %h/%b want 59/1", d_oc, d_cf); end
    n_vec++; if (a_cc !== 16'd0) begin n_err++; $display("FAIL dec1_cnt_pre got %0d want 0", a_cc); end
    @(negedge clk);
    exp_ca++;
    n_vec++; if (a_cc !== 16'(exp_ca)) begin n_err++; $display("FAIL dec1_cnt got %0d want %0d", a_cc, exp_ca); end
  endtask

  task automatic test_decode_double();
    xfer(1, 4'h0, 8'h41, 11'h0, 16'h0);
    n_vec++; if (a_uf !== 1'b1 || a_cf !== 1'b0) begin n_err++; $display("FAIL dec2_flags got u%b c%b want u1 c0", a_uf, a_cf); end
    n_vec++; if (a_od !== 4'b1000 || a_oc !== 8'h41) begin n_err++; $display("FAIL dec2_raw got %b/%h want 1000/41", a_od, a_oc); end
    xfer(1, 4'h0, 8'hD9, 11'h0, 16'h0);
    exp_ua++;
    n_vec++; if (a_uc !== 16'(exp_ua)) begin n_err++; $display("FAIL dec2_ucnt got %0d want %0d", a_uc, exp_ua); end
    n_vec++; if (a_cf !== 1'b1 || a_oc !== 8'h59 || a_os !== 3'b000) begin n_err++; $display("FAIL dec_ovr got c%b %h s%b want c1 59 s000", a_cf, a_oc, a_os); end
    n_vec++; if (d_cf !== 1'b0 || d_oc !== 7'h59) begin n_err++; $display("FAIL dec_sec_clean got %b/%h want 0/59", d_cf, d_oc); end
    @(negedge clk);
    exp_ca++;
    n_vec++; if (a_cc !== 16'(exp_ca)) begin n_err++; $display("FAIL dec_ovr_cnt got %0d want %0d", a_cc, exp_ca); end
  endtask

  task automatic test_secded_11();
    logic [10:0] w;
    logic [15:0] c, e;
    logic [3:0] s;
    int k1, k2;
    w = 11'($urandom_range(0, 2047));
    c = enc11(w);
    xfer(0, 4'h0, 8'h00, w, 16'h0);
    n_vec++; if (b_oc !== c) begin n_err++; $display("FAIL enc11_rand got %h want %h", b_oc, c); end
    for (int k = 0; k < 16; k++) begin
      e = c ^ (16'h1 << k);
      s = k < 4 ? 4'(1 << k) : k < 15 ? 4'(pos11[k-4]) : 4'h0;
      xfer(1, 4'h0, 8'h59, 11'h0, e);
      n_vec++; if (b_cf !== 1'b1 || b_uf !== 1'b0) begin n_err++; $display("FAIL d11_flip%0d_flags got c%b u%b want c1 u0", k, b_cf, b_uf); end
      n_vec++; if (b_oc !== c || b_od !== w) begin n_err++; $display("FAIL d11_flip%0d_fix got %h/%h want %h/%h", k, b_oc, b_od, c, w); end
      n_vec++; if (b_os !== s) begin n_err++; $display("FAIL d11_flip%0d_syn got %h want %h", k, b_os, s); end
    end
    for (int t = 0; t < 8; t++) begin
      k1 = $urandom_range(0, 15);
      k2 = (k1 + $urandom_range(1, 15)) % 16;
      e = c ^ (16'h1 << k1) ^ (16'h1 << k2);
      xfer(1, 4'h0, 8'h59, 11'h0, e);
      n_vec++; if (b_uf !== 1'b1 || b_cf !== 1'b0 || b_oc !== e) begin n_err++; $display("FAIL d11_dbl%0d_%0d got u%b c%b %h want u1 c0 %h", k1, k2, b_uf, b_cf, b_oc, e); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] wd[3] = '{4'h1, 4'hB, 4'hF};
    logic [7:0] wc[3] = '{8'h8B, 8'h59, 8'hFF};
    in_mode = 0;
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        n_vec++; if (a_ov !== 1'b1 || a_oc !== wc[i-2]) begin n_err++; $display("FAIL b2b_out%0d got v%b %h want v1 %h", i - 2, a_ov, a_oc, wc[i-2]); end
      end
      n_vec++; if (a_ir !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d got %b want 1", i, a_ir); end
      in_valid = i < 3;
      a_data = wd[i % 3];
      @(negedge clk);
    end
    in_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_mode = 0; in_valid = 1; a_data = 4'h1;
    @(negedge clk);
    n_vec++; if (a_ir !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got %b want 1", a_ir); end
    a_data = 4'hB;
    @(negedge clk);
    a_data = 4'hF;
    n_vec++; if (a_ir !== 1'b0) begin n_err++; $display("FAIL bp_ready2 got %b want 0", a_ir); end
    n_vec++; if (a_ov !== 1'b1 || a_oc !== 8'h8B) begin n_err++; $display("FAIL bp_hold0 got v%b %h want v1 8b", a_ov, a_oc); end
    repeat (2) @(negedge clk);
    n_vec++; if (a_ir !== 1'b0 || a_oc !== 8'h8B) begin n_err++; $display("FAIL bp_stall got r%b %h want r0 8b", a_ir, a_oc); end
    out_ready = 1;
    #1;
    n_vec++; if (a_ir !== 1'b1) begin n_err++; $display("FAIL bp_release got %b want 1", a_ir); end
    @(negedge clk);
    in_valid = 0;
    n_vec++; if (a_ov !== 1'b1 || a_oc !== 8'h59) begin n_err++; $display("FAIL bp_out1 got v%b %h want v1 59", a_ov, a_oc); end
    @(negedge clk);
    n_vec++; if (a_ov !== 1'b1 || a_oc !== 8'hFF) begin n_err++; $display("FAIL bp_out2 got v%b %h want v1 ff", a_ov, a_oc); end
    @(negedge clk);
    n_vec++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", a_ov); end
  endtask

  task automatic test_saturate_clear();
    rst_c = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) xfer(1, 4'h0, 8'h79, 11'h0, 16'h0);
    @(negedge clk);
    exp_ca += 5;
    n_vec++; if (c_cc !== 2'd3) begin n_err++; $display("FAIL sat_cnt got %0d want 3", c_cc); end
    n_vec++; if (a_cc !== 16'(exp_ca)) begin n_err++; $display("FAIL sat_wide_cnt got %0d want %0d", a_cc, exp_ca); end
    xfer(1, 4'h0, 8'h79, 11'h0, 16'h0);
    cnt_clear = 1;
    @(negedge clk);
    cnt_clear = 0;
    exp_ca = 0; exp_ua = 0;
    n_vec++; if (c_cc !== 2'd0 || a_cc !== 16'(exp_ca)) begin n_err++; $display("FAIL clr_corr got %0d/%0d want 0/0", c_cc, a_cc); end
    n_vec++; if (a_uc !== 16'(exp_ua)) begin n_err++; $display("FAIL clr_uncorr got %0d want 0", a_uc); end
  endtask

  task automatic test_reset_midstream();
    xfer(1, 4'h0, 8'h79, 11'h0, 16'h0);
    @(negedge clk);
    exp_ca++;
    n_vec++; if (c_cc !== 2'd1) begin n_err++; $display("FAIL mid_pre_cnt got %0d want 1", c_cc); end
    out_ready = 0; in_valid = 1; in_mode = 1; a_code = 8'h79;
    repeat (2) @(negedge clk);
    in_valid = 0;
    n_vec++; if (c_ov !== 1'b1 || c_cf !== 1'b1) begin n_err++; $display("FAIL mid_full got v%b c%b want v1 c1", c_ov, c_cf); end
    rst_c = 0;
    @(negedge clk);
    n_vec++; if (c_ov !== 1'b0 || c_oc !== 8'h00 || c_od !== 4'h0 || c_os !== 3'b000 || c_om !== 1'b0) begin n_err++; $display("FAIL mid_rst_out got v%b %h %h %b m%b want all 0", c_ov, c_oc, c_od, c_os, c_om); end
    n_vec++; if (c_cf !== 1'b0 || c_uf !== 1'b0 || c_cc !== 2'd0 || c_uc !== 2'd0) begin n_err++; $display("FAIL mid_rst_flags got %b%b %0d %0d want 00 0 0", c_cf, c_uf, c_cc, c_uc); end
    rst_c = 1;
    @(negedge clk);
    n_vec++; if (c_ir !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready got %b want 1", c_ir); end
    out_ready = 1;
    repeat (4) @(negedge clk);
    exp_ca += 2;
    n_vec++; if (c_ov !== 1'b0 || c_cc !== 2'd0) begin n_err++; $display("FAIL mid_discard got v%b %0d want v0 0", c_ov, c_cc); end
    n_vec++; if (a_cc !== 16'(exp_ca)) begin n_err++; $display("FAIL mid_other_lane got %0d want %0d", a_cc, exp_ca); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_decode_single();
    test_decode_double();
    test_secded_11();
    test_back_to_back();
    test_backpressure();
    test_saturate_clear();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hamming_codec.md
# hamming_codec

Parametrised, pipelined Hamming encoder/decoder with optional SEC-DED extension, valid/ready handshaking on both sides, and saturating error counters. It sits on the datapath between a data source and a storage or link stage and encodes outgoing words. In the same instance it checks and corrects returning codewords, chosen per transaction by a mode bit. For DATA_W=4, SECDED=0 the codeword is bit-identical to the team's existing Hamming(7,4) layout.

## Interface
- DATA_W, 4: data bits per word, 1..57.
- SECDED, 1: 1 adds an overall parity bit (double-error detection); 0 gives plain SEC.
- CNT_W, 16: width of each error counter.
- Derived R: smallest integer with 2^R >= DATA_W+R+1.
- Derived CW: DATA_W+R+SECDED, the codeword width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  synchronous, active-low reset.
- InValid  in  1  input word present.
- InReady  out  1  block accepts the input word this cycle.
- InMode  in  1  0 = encode, 1 = decode.
- InData  in  DATA_W  data to encode (ignored in decode).
- InCode  in  CW  codeword to decode (ignored in encode).
- OutValid  out  1  result present.
- OutReady  in  1  consumer accepts the result.
- OutMode  out  1  mode of the result.
- OutData  out  DATA_W  encode: InData echo; decode: corrected data.
- OutCode  out  CW  encode: codeword; decode: corrected codeword.
- OutSyndrome  out  R  decode syndrome; 0 in encode.
- OutCorrected  out  1  a single error was corrected.
- OutUncorrectable  out  1  the error was detected but not corrected.
- CntClear  in  1  synchronous clear of both counters.
- CorrCount  out  CNT_W  count of corrected words, saturating.
- UncorrCount  out  CNT_W  count of uncorrectable words, saturating.

## Operation
- Codeword layout is {overall parity if SECDED, Data[DATA_W-1:0], P[R-1:0]}.
- Hamming positions start at 1.
  - P[i] sits at position 2^i.
  - Data bit j sits at the j-th non-power-of-two position, counting from 3 (so d0→3, d1→5, d2→6, d3→7).
- P[i] is the XOR of every data bit whose position has bit i set. The overall parity bit is the XOR of Data and P.
- Decode:
  - S = recomputed P XOR received P.
  - O = XOR of all CW received bits; O is forced to 0 when SECDED=0.
- Decode classification with SECDED=1:
  - S=0, O=0: clean.
  - O=1, S=0: error in the overall bit. Flip it and set Corrected.
  - O=1, 1<=S<=DATA_W+R: flip the bit at position S (data or parity). Set Corrected.
  - O=1, S>DATA_W+R (shortened code): set Uncorrectable.
  - O=0, S≠0: double error. Set Uncorrectable.
- Decode classification with SECDED=0:
  - S≠0 and valid position: flip the bit and set Corrected.
  - Invalid position: set Uncorrectable.
- When Uncorrectable is set, OutData and OutCode carry the received bits unmodified.
- Encode always gives OutSyndrome=0, OutCorrected=0 and OutUncorrectable=0.
- Counters:
  - CorrCount increments by 1 on every output handshake (OutValid&&OutReady) with OutCorrected=1.
  - UncorrCount increments by 1 on every output handshake with OutUncorrectable=1.
  - Both hold at 2^CNT_W-1.
  - CntClear has priority over increment; the count is 0 on the following cycle.

## Timing
- Two-stage pipeline.
  - Stage 1 registers mode, data/code and S/O.
  - Stage 2 registers the classified and corrected result onto the Out* ports.
- Latency is 2 cycles from the input handshake to OutValid with no stall.
- Throughput is 1 word per cycle.
- Advance rule:
  - adv2 = !v2 || OutReady.
  - adv1 = !v1 || adv2.
  - InReady = adv1, combinational from OutReady. No combinational path from InValid to InReady.
- Stall behaviour:
  - While OutValid=1 and OutReady=0, all Out* ports hold stable.
  - Stage 1 holds once it is full.
  - InReady=0 after 2 words are buffered.
- No bubbles: with OutReady held high, back-to-back inputs give back-to-back outputs.
- Reset, including mid-transfer:
  - Stage valids, OutValid, all Out* data/flags, CorrCount and UncorrCount go to 0.
  - In-flight words are discarded.
  - InReady=1 on the first cycle after reset deasserts.

## Test plan
- Encode, DATA_W=4, SECDED=1: InData=4'b1011 → after 2 cycles OutCode=8'h59, syndrome 0, no flags.
- Decode single-bit error: InCode=8'h79 (d2 flipped) → OutData=4'b1011, OutCode=8'h59, OutSyndrome=3'b110, OutCorrected=1, CorrCount 0→1.
- Decode double error: InCode=8'h41 → OutUncorrectable=1, OutData=4'b1000 raw, UncorrCount increments. Also InCode=8'hD9 (overall bit only) → OutCorrected=1, OutCode=8'h59, OutSyndrome=0.
- Backpressure: send 3 consecutive words with OutReady=0 → InReady drops after word 2. Release OutReady → the 3 outputs appear in order, none lost or duplicated.
- DATA_W=11, SECDED=1 (CW=16, R=4): exhaustive single-bit flips over all 16 positions of a random word → all corrected. Random double flips → all Uncorrectable.
- CNT_W=2: 5 corrected words → CorrCount saturates at 3. CntClear asserted during an increment → 0. Rst_n low mid-stream → all outputs 0 next cycle.
